// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package : mips_pkg
// Purpose : Shared definitions for the pipelined MIPS front end.
//           - fetch_state_t : instruction-fetch FSM encoding
//           - RESET_PC      : default first fetch address after reset
//           - NOP_INSTR     : instruction value held in IF/ID while empty
//           - PC_STEP       : byte distance between sequential instructions
// Revision: 1.0 - initial release
// ============================================================================
package mips_pkg;

  // IDLE  : one cycle after reset before the first request goes out
  // FETCH : request outstanding (or about to be) on the current pc
  // HELD  : a fetched instruction is parked in the hold buffer
  // DROP  : request still in flight but its data will be discarded
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HELD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_STEP   = 4;

endpackage
`default_nettype wire

// File: rtl/mips_fetch_stage_adder.sv
`default_nettype none
// ============================================================================
// Module  : Adder_MIPS
// Purpose : Plain modulo-2^WIDTH adder used for the pc+4 computation.
// Ports   : a, b - operands
//           sum  - a + b, carry-out discarded (wraps)
// Revision: 1.0 - initial release
// ============================================================================
module Adder_MIPS #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule
`default_nettype wire

// File: rtl/mips_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : mips_fetch_stage
// Purpose : Instruction-fetch stage. Owns the PC, issues one outstanding
//           request at a time to instruction memory (req/ack), holds the
//           IF/ID pipeline register and a one-entry hold buffer that absorbs
//           decode stalls. Redirects from decode flush the stage.
// Ports   : clk, rst (async, active low)
//           imem_req/imem_addr  -> instruction memory request
//           imem_ack/imem_rdata <- instruction memory response
//           stall               <- decode cannot take a new IF/ID entry
//           redirect/redirect_pc<- taken branch/jump target from decode
//           pc                  -> current fetch PC
//           if_id_valid/instr/pcplus4 -> IF/ID pipeline register
// Revision: 1.0 - initial release
// ============================================================================
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter int                  pc_width      = 32,
  parameter int                  Ins_mem_width = 32,
  parameter logic [pc_width-1:0] reset_pc      = pc_width'(RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [pc_width-1:0]      imem_addr,
  input  logic                     imem_ack,
  input  logic [Ins_mem_width-1:0] imem_rdata,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [pc_width-1:0]      redirect_pc,
  output logic [pc_width-1:0]      pc,
  output logic                     if_id_valid,
  output logic [Ins_mem_width-1:0] if_id_instr,
  output logic [pc_width-1:0]      if_id_pcplus4
);

  localparam logic [pc_width-1:0]      c_pc_step = pc_width'(PC_STEP);
  localparam logic [Ins_mem_width-1:0] c_nop     = Ins_mem_width'(NOP_INSTR);

  fetch_state_t             r_state;
  logic [Ins_mem_width-1:0] r_hold_instr;
  logic [pc_width-1:0]      r_hold_pcplus4;
  logic [pc_width-1:0]      r_pend_pc;
  logic [pc_width-1:0]      w_pcplus4;

  Adder_MIPS #(
    .WIDTH (pc_width)
  ) u_pc_adder (
    .a   (pc),
    .b   (c_pc_step),
    .sum (w_pcplus4)
  );

  // The request is a pure decode of the state register, so the async reset
  // of r_state drops it immediately. The address is the pc itself; pc only
  // moves on an ack edge, which keeps the address stable while waiting.
  assign imem_req  = (r_state == FETCH) || (r_state == DROP);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      pc             <= reset_pc;
      if_id_valid    <= 1'b0;
      if_id_instr    <= c_nop;
      if_id_pcplus4  <= '0;
      r_hold_instr   <= c_nop;
      r_hold_pcplus4 <= '0;
      r_pend_pc      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
        end

        FETCH: begin
          if (imem_ack) begin
            if (redirect) begin
              // Fetched word is on the wrong path; restart at the target.
              pc          <= redirect_pc;
              if_id_valid <= 1'b0;
            end else if (stall) begin
              // Decode is busy: park the word and pause requests.
              r_hold_instr   <= imem_rdata;
              r_hold_pcplus4 <= w_pcplus4;
              pc             <= w_pcplus4;
              r_state        <= HELD;
            end else begin
              if_id_valid   <= 1'b1;
              if_id_instr   <= imem_rdata;
              if_id_pcplus4 <= w_pcplus4;
              pc            <= w_pcplus4;
            end
          end else if (redirect) begin
            // Cannot move the address mid-request; remember the target and
            // let the in-flight access complete into the bit bucket.
            r_pend_pc   <= redirect_pc;
            if_id_valid <= 1'b0;
            r_state     <= DROP;
          end else if (!stall) begin
            // Decode consumed the entry and nothing new arrived: bubble.
            if_id_valid <= 1'b0;
          end
        end

        HELD: begin
          if (redirect) begin
            pc          <= redirect_pc;
            if_id_valid <= 1'b0;
            r_state     <= FETCH;
          end else if (!stall) begin
            if_id_valid   <= 1'b1;
            if_id_instr   <= r_hold_instr;
            if_id_pcplus4 <= r_hold_pcplus4;
            r_state       <= FETCH;
          end
        end

        DROP: begin
          if (imem_ack) begin
            // A redirect arriving on the ack cycle is the newest target.
            pc      <= redirect ? redirect_pc : r_pend_pc;
            r_state <= FETCH;
          end else if (redirect) begin
            r_pend_pc <= redirect_pc;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
